// File: rtl/wbu_pkg.sv
// Shared definitions for the write-back stage: FSM states, retire packet layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// The bit-position localparams are the single source of truth for the retire
// packet layout; the LSU packer builds lsu_data from the same constants.
package wbu_pkg;

  // Stage FSM. Encoding is fixed here so every consumer agrees on it.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_COMMIT = 2'd2,
    S_HALT   = 2'd3
  } wbu_state_t;

  // Retire packet layout (lsu_data).
  localparam int PKT_W    = 104;
  localparam int RES_MSB  = 103;  // ALU result
  localparam int RES_LSB  = 72;
  localparam int LD_MSB   = 71;   // load data, already sign/zero extended
  localparam int LD_LSB   = 40;
  localparam int PC_MSB   = 39;   // pc of the retiring instruction
  localparam int PC_LSB   = 8;
  localparam int RD_MSB   = 7;    // destination register
  localparam int RD_LSB   = 3;
  localparam int WEN_BIT  = 2;    // register file write enable
  localparam int M2R_BIT  = 1;    // select load data instead of ALU result
  localparam int EBRK_BIT = 0;    // instruction is ebreak

  localparam int XLEN   = 32;
  localparam int RADDR_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]    result;
    logic [XLEN-1:0]    ld_data;
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] rd;
    logic               rf_wen;
    logic               mem_to_reg;
    logic               ebreak;
  } wbu_pkt_t;

  // Unpack a raw retire word into the packet struct using the named positions,
  // so a layout change only has to be made in the localparams above.
  function automatic wbu_pkt_t unpack_pkt(input logic [PKT_W-1:0] raw);
    wbu_pkt_t p;
    p.result     = raw[RES_MSB:RES_LSB];
    p.ld_data    = raw[LD_MSB:LD_LSB];
    p.pc         = raw[PC_MSB:PC_LSB];
    p.rd         = raw[RD_MSB:RD_LSB];
    p.rf_wen     = raw[WEN_BIT];
    p.mem_to_reg = raw[M2R_BIT];
    p.ebreak     = raw[EBRK_BIT];
    return p;
  endfunction

endpackage

// File: rtl/wbu_regfile.sv
// Integer register file: one synchronous write port, two combinational read ports.
// Latency: write visible on read ports the cycle after the write edge; reads are 0-cycle.
// Backpressure: none; every write is taken on the clock edge it is presented.
//
// Ports:
//   clk_i, rst_ni         clock, async active-low clear of every register
//   we_i, waddr_i, wdata_i write port (x0 and out-of-range addresses ignored)
//   raddr1_i / rdata1_o   read port 1
//   raddr2_i / rdata2_o   read port 2
// x0 is not stored; it and any address >= NR_REGS read as zero. There is no
// write-to-read bypass: a read during the write cycle returns the old value.
module wbu_regfile
  import wbu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NR_REGS = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [RADDR_W-1:0] raddr1_i,
  output logic [WIDTH-1:0]   rdata1_o,
  input  logic [RADDR_W-1:0] raddr2_i,
  output logic [WIDTH-1:0]   rdata2_o
);

  // Entries 1..NR_REGS-1 only; x0 has no storage.
  logic [WIDTH-1:0] mem_q [1:NR_REGS-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NR_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      // Address decode by comparison keeps the 5-bit address legal for the
      // 16-entry variant; out-of-range addresses simply match nothing.
      for (int i = 1; i < NR_REGS; i++) begin
        if (waddr_i == RADDR_W'(i)) begin
          mem_q[i] <= wdata_i;
        end
      end
    end
  end

  always_comb begin
    rdata1_o = '0;
    for (int i = 1; i < NR_REGS; i++) begin
      if (raddr1_i == RADDR_W'(i)) begin
        rdata1_o = mem_q[i];
      end
    end
  end

  always_comb begin
    rdata2_o = '0;
    for (int i = 1; i < NR_REGS; i++) begin
      if (raddr2_i == RADDR_W'(i)) begin
        rdata2_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/wbu.sv
// Write-back stage: buffers one retire packet, writes the register file, reports commit.
// Latency: accept -> commit_valid 2 cycles; best-case one packet per 3 cycles.
// Backpressure: wbu_ready only in S_IDLE; commit held stable until commit_ready; halted forever after ebreak.
//
// Ports:
//   clk, rst                         clock, async active-low reset
//   lsu_valid, lsu_data, wbu_ready   retire packet handshake from the LSU
//   rs1_addr/rs1_data, rs2_addr/rs2_data
//                                    combinational register file reads for decode
//   commit_valid, commit_pc, commit_ready
//                                    commit handshake towards fetch
//   halt                             sticky, ebreak has been committed
//   bad_rd                           sticky, a write to rd >= NR_REGS was dropped
module wbu
  import wbu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NR_REGS = 32   // 16 (RV32E) or 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lsu_valid,
  input  logic [PKT_W-1:0]   lsu_data,
  output logic               wbu_ready,
  input  logic [RADDR_W-1:0] rs1_addr,
  output logic [WIDTH-1:0]   rs1_data,
  input  logic [RADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]   rs2_data,
  output logic               commit_valid,
  output logic [XLEN-1:0]    commit_pc,
  input  logic               commit_ready,
  output logic               halt,
  output logic               bad_rd
);

  wbu_state_t state_q, state_d;
  wbu_pkt_t   pkt_q, pkt_d;
  logic       halt_q, halt_d;
  logic       bad_rd_q, bad_rd_d;

  logic             rf_we;
  logic [WIDTH-1:0] rf_wdata;
  logic             rd_in_range;

  assign rd_in_range = (int'(pkt_q.rd) < NR_REGS);
  assign rf_wdata    = pkt_q.mem_to_reg ? WIDTH'(pkt_q.ld_data) : WIDTH'(pkt_q.result);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pkt_q    <= '0;
      halt_q   <= 1'b0;
      bad_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      halt_q   <= halt_d;
      bad_rd_q <= bad_rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    halt_d   = halt_q;
    bad_rd_d = bad_rd_q;
    rf_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // wbu_ready is implied by being in S_IDLE.
        if (lsu_valid) begin
          pkt_d   = unpack_pkt(lsu_data);
          state_d = S_WB;
        end
      end

      S_WB: begin
        // x0 writes vanish silently; only a real out-of-range rd is flagged.
        if (pkt_q.rf_wen && (pkt_q.rd != '0)) begin
          if (rd_in_range) begin
            rf_we = 1'b1;
          end else begin
            bad_rd_d = 1'b1;
          end
        end
        state_d = S_COMMIT;
      end

      S_COMMIT: begin
        if (commit_ready) begin
          if (pkt_q.ebreak) begin
            halt_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_HALT: begin
        // Terminal; only reset leaves.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decoded from the state register so both read their reset values while rst is low.
  assign wbu_ready    = (state_q == S_IDLE);
  assign commit_valid = (state_q == S_COMMIT);
  assign commit_pc    = pkt_q.pc;
  assign halt         = halt_q;
  assign bad_rd       = bad_rd_q;

  wbu_regfile #(
    .WIDTH   (WIDTH),
    .NR_REGS (NR_REGS)
  ) u_regfile (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (rf_we),
    .waddr_i  (pkt_q.rd),
    .wdata_i  (rf_wdata),
    .raddr1_i (rs1_addr),
    .rdata1_o (rs1_data),
    .raddr2_i (rs2_addr),
    .rdata2_o (rs2_data)
  );

endmodule

// File: tb/tb_wbu.sv
// Bench for wbu: two instances (32 and 16 registers) share all stimulus and are
// compared against per-instance architectural register models.
module tb_wbu;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         lsu_valid;
  logic [103:0] lsu_data;
  logic [4:0]   rs1_addr, rs2_addr;
  logic         commit_ready;

  logic        rdy_a, cv_a, halt_a, bad_a;
  logic [31:0] rs1_a, rs2_a, cpc_a;
  logic        rdy_b, cv_b, halt_b, bad_b;
  logic [31:0] rs1_b, rs2_b, cpc_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Architectural model: 32-entry and 16-entry register files, sticky flags.
  logic [31:0] m32 [32];
  logic [31:0] m16 [16];
  logic        bad32, bad16;

  always #5 clk = ~clk;

  wbu #(.WIDTH(32), .NR_REGS(32)) dut_a (
    .clk(clk), .rst(rst_n), .lsu_valid(lsu_valid), .lsu_data(lsu_data), .wbu_ready(rdy_a),
    .rs1_addr(rs1_addr), .rs1_data(rs1_a), .rs2_addr(rs2_addr), .rs2_data(rs2_a),
    .commit_valid(cv_a), .commit_pc(cpc_a), .commit_ready(commit_ready),
    .halt(halt_a), .bad_rd(bad_a)
  );

  wbu #(.WIDTH(32), .NR_REGS(16)) dut_b (
    .clk(clk), .rst(rst_n), .lsu_valid(lsu_valid), .lsu_data(lsu_data), .wbu_ready(rdy_b),
    .rs1_addr(rs1_addr), .rs1_data(rs1_b), .rs2_addr(rs2_addr), .rs2_data(rs2_b),
    .commit_valid(cv_b), .commit_pc(cpc_b), .commit_ready(commit_ready),
    .halt(halt_b), .bad_rd(bad_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd32(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : m32[a];
  endfunction

  function automatic logic [31:0] rd16(input logic [4:0] a);
    return (a == 5'd0 || a >= 5'd16) ? 32'h0 : m16[a[3:0]];
  endfunction

  function automatic logic [103:0] mk(input logic [31:0] res, input logic [31:0] ld,
                                      input logic [31:0] pc, input logic [4:0] rd,
                                      input logic wen, input logic m2r, input logic eb);
    return {res, ld, pc, rd, wen, m2r, eb};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m32[i] = 32'h0;
    for (int i = 0; i < 16; i++) m16[i] = 32'h0;
    bad32 = 1'b0;
    bad16 = 1'b0;
  endtask

  // Architectural effect of one retired packet.
  task automatic model_apply(input logic [103:0] p);
    logic [31:0] w;
    logic [4:0]  rd;
    w  = p[1] ? p[71:40] : p[103:72];
    rd = p[7:3];
    if (p[2] && rd != 5'd0) begin
      m32[rd] = w;
      if (rd < 5'd16) m16[rd[3:0]] = w;
      else            bad16 = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [103:0] junk();
    return {$urandom, $urandom, $urandom, 8'($urandom)};
  endfunction

  task automatic check_flags();
    chk("bad_rd_a", {31'h0, bad_a}, {31'h0, bad32});
    chk("bad_rd_b", {31'h0, bad_b}, {31'h0, bad16});
  endtask

  task automatic dump_regs();
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      chk("dump rs1_a", rs1_a, rd32(rs1_addr));
      chk("dump rs2_a", rs2_a, rd32(rs2_addr));
      chk("dump rs1_b", rs1_b, rd16(rs1_addr));
      chk("dump rs2_b", rs2_b, rd16(rs2_addr));
    end
  endtask

  // Full accept / write-back / commit sequence, holding commit_ready low for
  // 'hold' cycles while throwing ignored lsu_valid pulses at the stage.
  task automatic send(input logic [103:0] p, input int hold);
    logic [4:0] rd;
    rd = p[7:3];
    chk("ready_a pre", {31'h0, rdy_a}, 32'h1);
    chk("ready_b pre", {31'h0, rdy_b}, 32'h1);
    lsu_data  = p;
    lsu_valid = 1'b1;
    tick();
    lsu_valid = 1'b0;
    lsu_data  = junk();
    // S_WB cycle: stage busy, no commit yet, old register value visible.
    chk("ready_a wb", {31'h0, rdy_a}, 32'h0);
    chk("cv_a wb", {31'h0, cv_a}, 32'h0);
    rs1_addr = rd;
    rs2_addr = 5'($urandom);
    #1;
    chk("rs1_a old", rs1_a, rd32(rd));
    chk("rs1_b old", rs1_b, rd16(rd));
    chk("rs2_a old", rs2_a, rd32(rs2_addr));
    tick();
    model_apply(p);
    chk("cv_a", {31'h0, cv_a}, 32'h1);
    chk("cv_b", {31'h0, cv_b}, 32'h1);
    chk("cpc_a", cpc_a, p[39:8]);
    chk("cpc_b", cpc_b, p[39:8]);
    chk("rs1_a new", rs1_a, rd32(rd));
    chk("rs1_b new", rs1_b, rd16(rd));
    chk("rs2_b new", rs2_b, rd16(rs2_addr));
    check_flags();
    for (int h = 0; h < hold; h++) begin
      lsu_valid = 1'b1;
      lsu_data  = junk();
      tick();
      lsu_valid = 1'b0;
      chk("cv_a hold", {31'h0, cv_a}, 32'h1);
      chk("cpc_a hold", cpc_a, p[39:8]);
      chk("ready_a hold", {31'h0, rdy_a}, 32'h0);
      chk("rs1_a hold", rs1_a, rd32(rd));
    end
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    chk("cv_a post", {31'h0, cv_a}, 32'h0);
    if (p[0]) begin
      chk("halt_a", {31'h0, halt_a}, 32'h1);
      chk("halt_b", {31'h0, halt_b}, 32'h1);
      chk("ready_a halted", {31'h0, rdy_a}, 32'h0);
    end else begin
      chk("halt_a", {31'h0, halt_a}, 32'h0);
      chk("ready_a post", {31'h0, rdy_a}, 32'h1);
      chk("ready_b post", {31'h0, rdy_b}, 32'h1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    #3;
    chk("rst ready_a", {31'h0, rdy_a}, 32'h1);
    chk("rst cv_a", {31'h0, cv_a}, 32'h0);
    chk("rst cpc_a", cpc_a, 32'h0);
    chk("rst halt_a", {31'h0, halt_a}, 32'h0);
    chk("rst halt_b", {31'h0, halt_b}, 32'h0);
    check_flags();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [103:0] p;
    rst_n        = 1'b0;
    lsu_valid    = 1'b0;
    lsu_data     = '0;
    rs1_addr     = '0;
    rs2_addr     = '0;
    commit_ready = 1'b0;
    clear_model();

    // Reset state, registers zero.
    do_reset();
    dump_regs();

    // Basic ALU write-back.
    send(mk(32'h0000_1234, 32'hCAFE_0000, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0), 0);
    rs1_addr = 5'd5; #1;
    chk("x5 const", rs1_a, 32'h0000_1234);

    // Load data selected, ALU result ignored.
    send(mk(32'h8000_0100, 32'hFFFF_FF80, 32'h8000_0004, 5'd10, 1'b1, 1'b1, 1'b0), 0);
    rs1_addr = 5'd10; #1;
    chk("x10 const", rs1_a, 32'hFFFF_FF80);
    chk("x10 const b", rs1_b, 32'hFFFF_FF80);

    // Write to x0 discarded without flag.
    send(mk(32'h0000_DEAD, 32'h0, 32'h8000_0008, 5'd0, 1'b1, 1'b0, 1'b0), 0);
    rs1_addr = 5'd0; #1;
    chk("x0 reads 0", rs1_a, 32'h0);
    chk("x0 no bad_rd", {31'h0, bad_a}, 32'h0);

    // rd=20: legal on 32-entry file, dropped and flagged on 16-entry file.
    send(mk(32'h5555_AAAA, 32'h0, 32'h8000_000C, 5'd20, 1'b1, 1'b0, 1'b0), 0);
    chk("bad_rd_b set", {31'h0, bad_b}, 32'h1);
    rs1_addr = 5'd20; #1;
    chk("x20 oob b", rs1_b, 32'h0);

    // Commit backpressure for 5 cycles, ignored lsu_valid pulses.
    send(mk($urandom, $urandom, 32'h8000_0020, 5'd3, 1'b1, 1'b0, 1'b0), 5);

    // Randomized traffic, non-halting.
    for (int n = 0; n < 40; n++) begin
      p = mk($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      send(p, int'($urandom_range(0, 2)));
    end
    chk("bad_rd_b sticky", {31'h0, bad_b}, 32'h1);
    dump_regs();

    // ebreak: halt and ignore further packets.
    send(mk(32'h1111_2222, 32'h0, 32'h8000_0010, 5'd7, 1'b1, 1'b0, 1'b1), 1);
    for (int k = 0; k < 3; k++) begin
      lsu_valid = 1'b1;
      lsu_data  = mk(32'h7777_7777, 32'h0, 32'h9000_0000, 5'd8, 1'b1, 1'b0, 1'b0);
      tick();
      lsu_valid = 1'b0;
      chk("halted ready_a", {31'h0, rdy_a}, 32'h0);
      chk("halted cv_a", {31'h0, cv_a}, 32'h0);
      chk("halted halt_a", {31'h0, halt_a}, 32'h1);
    end
    tick();
    dump_regs();

    // Asynchronous reset in the middle of S_COMMIT.
    do_reset();
    lsu_data  = mk(32'hABCD_0123, 32'h0, 32'h8000_0040, 5'd7, 1'b1, 1'b0, 1'b0);
    lsu_valid = 1'b1;
    tick();
    lsu_valid = 1'b0;
    tick();
    chk("mid cv_a", {31'h0, cv_a}, 32'h1);
    rs1_addr = 5'd7; #1;
    chk("mid x7", rs1_a, 32'hABCD_0123);
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("arst cv_a", {31'h0, cv_a}, 32'h0);
    chk("arst cv_b", {31'h0, cv_b}, 32'h0);
    chk("arst x7", rs1_a, 32'h0);
    chk("arst ready_a", {31'h0, rdy_a}, 32'h1);
    chk("arst cpc_a", cpc_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post ready_a", {31'h0, rdy_a}, 32'h1);
    chk("post cv_a", {31'h0, cv_a}, 32'h0);
    send(mk(32'h0BAD_F00D, 32'h0, 32'h8000_0080, 5'd1, 1'b1, 1'b0, 1'b0), 0);
    dump_regs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
